// File: rtl/troy_ifetch_pkg.sv
// Shared types and constants for the Troy instruction-fetch front-end.
package troy_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_W    = 32;

  localparam logic [0:PC_W-1]    PC_INC        = 32'd4;
  localparam logic [0:PC_W-1]    PC_ALIGN_MASK = 32'h0000_0003;
  localparam logic [0:INSTR_W-1] HALT_INSTR    = 32'h0000_0000;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } ifetch_state_e;

  typedef struct packed {
    logic [0:INSTR_W-1] instr;
    logic [0:PC_W-1]    pc;
  } fetch_entry_t;

endpackage

// File: rtl/troy_ifetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetched {instr, pc}; flush beats push.
module troy_ifetch_fifo
  import troy_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t pushEntry,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W:0]   count;
  logic             doPush;
  logic             doPop;

  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      mem   <= '{default: '0};
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) begin
        mem[wrPtr] <= pushEntry;
        wrPtr      <= wrPtr + 1'b1;
      end
      if (doPop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign full  = (count == (PTR_W + 1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rdPtr];

endmodule

// File: rtl/troy_ifetch.sv
// Troy instruction fetch: PC, imem addressing, fetch buffer, redirect and halt.
// Optional performance counters enabled by defining TROY_IFETCH_PERF_EN.
module troy_ifetch
  import troy_pkg::*;
#(
  parameter int unsigned     DEPTH    = 2,
  parameter logic [0:PC_W-1] PC_RESET = 32'h0000_0000,
  parameter int unsigned     IMEM_AW  = 8
) (
  input  logic               clk,
  input  logic               reset,
  output logic [0:IMEM_AW-1] imem_addr,
  input  logic [0:31]        imem_data,
  output logic [0:31]        out_instr,
  output logic [0:31]        out_pc,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic               redirect_valid,
  input  logic [0:31]        redirect_pc,
  output logic               halted
`ifdef TROY_IFETCH_PERF_EN
  ,
  output logic [0:31]        perf_fetch_cnt,
  output logic [0:31]        perf_stall_cnt
`endif
);

  ifetch_state_e   state;
  ifetch_state_e   stateNext;
  logic [0:PC_W-1] fetchPc;
  logic [0:PC_W-1] fetchPcNext;
  logic            haltedNext;
  logic            push;
  logic            pop;
  logic            flush;
  logic            fifoFull;
  logic            fifoEmpty;
  fetch_entry_t    head;

  troy_ifetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .Clk      (clk),
    .Reset    (reset),
    .push     (push),
    .pop      (pop),
    .flush    (flush),
    .pushEntry('{instr: imem_data, pc: fetchPc}),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .head     (head)
  );

  assign out_valid = !fifoEmpty;
  assign out_instr = head.instr;
  assign out_pc    = head.pc;
  assign pop       = out_valid && out_ready;
  assign imem_addr = fetchPc[(30 - IMEM_AW):29];

  always_comb begin
    stateNext   = state;
    fetchPcNext = fetchPc;
    haltedNext  = halted;
    push        = 1'b0;
    flush       = 1'b0;
    if (redirect_valid) begin
      flush       = 1'b1;
      fetchPcNext = redirect_pc & ~PC_ALIGN_MASK;
      stateNext   = RUN;
      haltedNext  = 1'b0;
    end else begin
      // Only the halt entry can hold HALT_INSTR: fetching stops right after it.
      if (pop && head.instr == HALT_INSTR) begin
        haltedNext = 1'b1;
      end
      if (state == RUN && (!fifoFull || pop)) begin
        push        = 1'b1;
        fetchPcNext = fetchPc + PC_INC;
        if (imem_data == HALT_INSTR) begin
          stateNext = HALT;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= RUN;
      fetchPc <= PC_RESET;
      halted  <= 1'b0;
    end else begin
      state   <= stateNext;
      fetchPc <= fetchPcNext;
      halted  <= haltedNext;
    end
  end

`ifdef TROY_IFETCH_PERF_EN
  logic stallCycle;
  assign stallCycle = (state == RUN) && fifoFull && !pop;

  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (push && perf_fetch_cnt != '1) begin
        perf_fetch_cnt <= perf_fetch_cnt + 1'b1;
      end
      if (stallCycle && perf_stall_cnt != '1) begin
        perf_stall_cnt <= perf_stall_cnt + 1'b1;
      end
    end
  end
`endif

endmodule
